// File: rtl/alu_pkg.sv
// Shared ALU control codes and EX-stage FSM encoding.
// Used by alu_exec_mc and alu_mul_iter.
package alu_pkg;

  localparam int CTRL_W = 6;

  localparam logic [CTRL_W-1:0] ALU_AND   = 6'h00;
  localparam logic [CTRL_W-1:0] ALU_OR    = 6'h01;
  localparam logic [CTRL_W-1:0] ALU_ADD   = 6'h02;
  localparam logic [CTRL_W-1:0] ALU_ADDU  = 6'h03;
  localparam logic [CTRL_W-1:0] ALU_XOR   = 6'h04;
  localparam logic [CTRL_W-1:0] ALU_SUB   = 6'h06;
  localparam logic [CTRL_W-1:0] ALU_SLT   = 6'h07;
  localparam logic [CTRL_W-1:0] ALU_SLTU  = 6'h08;
  localparam logic [CTRL_W-1:0] ALU_LUI   = 6'h09;
  localparam logic [CTRL_W-1:0] ALU_SLL1  = 6'h0A;
  localparam logic [CTRL_W-1:0] ALU_SLL2  = 6'h0B;
  localparam logic [CTRL_W-1:0] ALU_SLL8  = 6'h0C;
  localparam logic [CTRL_W-1:0] ALU_SRL1  = 6'h0D;
  localparam logic [CTRL_W-1:0] ALU_SRL2  = 6'h0E;
  localparam logic [CTRL_W-1:0] ALU_SRL8  = 6'h0F;
  localparam logic [CTRL_W-1:0] ALU_SRA1  = 6'h10;
  localparam logic [CTRL_W-1:0] ALU_SRA2  = 6'h11;
  localparam logic [CTRL_W-1:0] ALU_SRA8  = 6'h12;
  localparam logic [CTRL_W-1:0] ALU_MULTU = 6'h13;
  localparam logic [CTRL_W-1:0] ALU_REF   = 6'h14;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// done is high for the cycle after the last iteration.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               run;

  assign done = run && (cnt == CW'(WIDTH));

  // mcand carries multiplicand<<cnt, mplier[0] is bit cnt of b
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      cnt     <= '0;
      run     <= 1'b0;
    end else if (abort) begin
      run <= 1'b0;
    end else if (start) begin
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      product <= '0;
      cnt     <= '0;
      run     <= 1'b1;
    end else if (run) begin
      if (done) begin
        run <= 1'b0;
      end else begin
        if (mplier[0]) product <= product + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_exec_mc.sv
// EX-stage execution unit: registered single-cycle ALU plus iterative MULTU.
// Optional signed-overflow output enabled by ALU_EXEC_OVF_EN.
module alu_exec_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  input  logic              flush,
  output logic              result_valid,
  output logic [WIDTH-1:0]  result,
  output logic              zero,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo,
`ifdef ALU_EXEC_OVF_EN
  output logic              ovf,
`endif
  output logic              busy
);

  state_t state_q, state_d;

  logic               accept;
  logic               is_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   alu_res;

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_MUL);
  assign is_mul   = (alu_ctrl == ALU_MULTU);
  assign accept   = in_valid && in_ready && !flush;
  assign sum      = op_a + op_b;
  assign diff     = op_a - op_b;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .abort   (flush),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (accept && is_mul) state_d = ST_MUL;
        ST_MUL:  if (mul_done) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      (alu_ctrl == ALU_AND):  alu_res = op_a & op_b;
      (alu_ctrl == ALU_OR):   alu_res = op_a | op_b;
      (alu_ctrl == ALU_XOR):  alu_res = op_a ^ op_b;
      (alu_ctrl == ALU_ADD),
      (alu_ctrl == ALU_ADDU): alu_res = sum;
      (alu_ctrl == ALU_SUB):  alu_res = diff;
      (alu_ctrl == ALU_SLT):
        alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      (alu_ctrl == ALU_SLTU):
        alu_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
      (alu_ctrl == ALU_LUI):  alu_res = op_b << 16;
      (alu_ctrl == ALU_SLL1): alu_res = op_b << 1;
      (alu_ctrl == ALU_SLL2): alu_res = op_b << 2;
      (alu_ctrl == ALU_SLL8): alu_res = op_b << 8;
      (alu_ctrl == ALU_SRL1): alu_res = op_b >> 1;
      (alu_ctrl == ALU_SRL2): alu_res = op_b >> 2;
      (alu_ctrl == ALU_SRL8): alu_res = op_b >> 8;
      (alu_ctrl == ALU_SRA1): alu_res = $signed(op_b) >>> 1;
      (alu_ctrl == ALU_SRA2): alu_res = $signed(op_b) >>> 2;
      (alu_ctrl == ALU_SRA8): alu_res = $signed(op_b) >>> 8;
      (alu_ctrl >= ALU_REF):  alu_res = '0;
      default:                alu_res = '0;
    endcase
  end

`ifdef ALU_EXEC_OVF_EN
  logic ovf_c;
  always_comb begin
    ovf_c = 1'b0;
    if (alu_ctrl == ALU_ADD)
      ovf_c = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
              (sum[WIDTH-1] != op_a[WIDTH-1]);
    else if (alu_ctrl == ALU_SUB)
      ovf_c = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
              (diff[WIDTH-1] != op_a[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          ovf <= 1'b0;
    else if (accept && !is_mul)          ovf <= ovf_c;
    else                                 ovf <= 1'b0;
  end
`endif

  // flush squashes both a fresh accept and a completing multiply
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_valid <= 1'b0;
      result       <= '0;
      zero         <= 1'b0;
      hi           <= '0;
      lo           <= '0;
    end else begin
      result_valid <= 1'b0;
      if (flush) begin
        result_valid <= 1'b0;
      end else if (accept && !is_mul) begin
        result       <= alu_res;
        zero         <= (alu_res == '0);
        result_valid <= 1'b1;
      end else if (busy && mul_done) begin
        hi           <= product[2*WIDTH-1:WIDTH];
        lo           <= product[WIDTH-1:0];
        result       <= product[WIDTH-1:0];
        zero         <= (product[WIDTH-1:0] == '0);
        result_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_mc.sv
// Directed-vector bench for alu_exec_mc.
// Build with ALU_EXEC_OVF_EN to also cover the ovf output.
module tb_alu_exec_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        result_valid;
  logic [31:0] result;
  logic        zero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
`ifdef ALU_EXEC_OVF_EN
  logic        ovf;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_exec_mc #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_ctrl     (alu_ctrl),
    .op_a         (op_a),
    .op_b         (op_b),
    .flush        (flush),
    .result_valid (result_valid),
    .result       (result),
    .zero         (zero),
    .hi           (hi),
    .lo           (lo),
`ifdef ALU_EXEC_OVF_EN
    .ovf          (ovf),
`endif
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single cycle, then sample 1ns after the edge
  task automatic op(input logic [5:0] c, input logic [31:0] a,
                    input logic [31:0] b);
    in_valid = 1'b1;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [31:0] r,
                         input logic z);
    chk({tag, "_rv"}, {31'd0, result_valid}, 32'd1);
    chk({tag, "_res"}, result, r);
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, z});
  endtask

  initial begin
    int n;
    int pulses;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    alu_ctrl = 6'h00;
    op_a     = '0;
    op_b     = '0;
    flush    = 1'b0;

    #12;
    chk("rst_rv", {31'd0, result_valid}, 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    #5 rst_n = 1'b1;
    cyc();

    op(6'h02, 32'h7FFF_FFFF, 32'h0000_0001);
    chk_res("add_ovf", 32'h8000_0000, 1'b0);
`ifdef ALU_EXEC_OVF_EN
    chk("add_ovf_flag", {31'd0, ovf}, 32'd1);
`endif
    cyc();
    chk("idle_rv", {31'd0, result_valid}, 32'd0);

    op(6'h06, 32'd5, 32'd5);
    chk_res("sub_zero", 32'd0, 1'b1);
`ifdef ALU_EXEC_OVF_EN
    chk("sub_ovf_flag", {31'd0, ovf}, 32'd0);
`endif

    op(6'h12, 32'd0, 32'h8000_0000);
    chk_res("sra8", 32'hFF80_0000, 1'b0);
    op(6'h0F, 32'd0, 32'h8000_0000);
    chk_res("srl8", 32'h0080_0000, 1'b0);
    op(6'h0B, 32'd0, 32'h0000_0001);
    chk_res("sll2", 32'h0000_0004, 1'b0);
    op(6'h09, 32'd0, 32'h0000_1234);
    chk_res("lui", 32'h1234_0000, 1'b0);
    op(6'h07, 32'hFFFF_FFFF, 32'd1);
    chk_res("slt", 32'd1, 1'b0);
    op(6'h08, 32'hFFFF_FFFF, 32'd1);
    chk_res("sltu", 32'd0, 1'b1);
    op(6'h00, 32'h0000_F0F0, 32'h0000_FF00);
    chk_res("and", 32'h0000_F000, 1'b0);
    op(6'h01, 32'h0000_F0F0, 32'h0000_FF00);
    chk_res("or", 32'h0000_FFF0, 1'b0);
    op(6'h04, 32'h0000_F0F0, 32'h0000_FF00);
    chk_res("xor", 32'h0000_0FF0, 1'b0);

    // MULTU max*max, with an ADD waiting behind it
    op(6'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    in_valid = 1'b1;
    alu_ctrl = 6'h02;
    op_a     = 32'd2;
    op_b     = 32'd3;
    n      = 0;
    pulses = 0;
    while (!in_ready && n < 100) begin
      n++;
      if (result_valid) pulses++;
      cyc();
    end
    chk("mul_lowcyc", n, 32'd33);
    chk("mul_early_rv", pulses, 32'd0);
    chk_res("mul_max", 32'h0000_0001, 1'b0);
    chk("mul_hi", hi, 32'hFFFF_FFFE);
    chk("mul_lo", lo, 32'h0000_0001);
    cyc();
    in_valid = 1'b0;
    chk_res("b2b_add", 32'd5, 1'b0);
    chk("b2b_hi", hi, 32'hFFFF_FFFE);

    // MULTU 3*4 flushed at iteration 5, with a competing in_valid
    op(6'h13, 32'd3, 32'd4);
    chk("mul2_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) cyc();
    flush    = 1'b1;
    in_valid = 1'b1;
    alu_ctrl = 6'h13;
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_rdy", {31'd0, in_ready}, 32'd1);
    chk("flush_rv", {31'd0, result_valid}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid) pulses++;
      cyc();
    end
    chk("flush_no_rv", pulses, 32'd0);
    chk("flush_hi", hi, 32'hFFFF_FFFE);
    chk("flush_lo", lo, 32'h0000_0001);

    op(6'h14, 32'd5, 32'd7);
    chk_res("ref14", 32'd0, 1'b1);
    op(6'h3F, 32'd5, 32'd7);
    chk_res("ref3f", 32'd0, 1'b1);
    op(6'h05, 32'd5, 32'd7);
    chk_res("ref05", 32'd0, 1'b1);
    chk("ref_hi", hi, 32'hFFFF_FFFE);

    // Reset asserted 10 cycles into a multiply
    op(6'h01, 32'h1, 32'h2);
    op(6'h13, 32'd7, 32'd9);
    for (int i = 0; i < 9; i++) cyc();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_rv", {31'd0, result_valid}, 32'd0);
    chk("mrst_res", result, 32'd0);
    chk("mrst_hi", hi, 32'd0);
    chk("mrst_lo", lo, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_rdy", {31'd0, in_ready}, 32'd1);
    op(6'h03, 32'd10, 32'd20);
    chk_res("post_rst_addu", 32'd30, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_exec_mc.md
Name: alu_exec_mc

Overview:
- Multi-cycle execution unit in the EX stage.
- Consumes the 6-bit ALU control code produced by the ALU controller, plus two operands.
- Executes single-cycle logic/arith/shift ops with 1-cycle registered latency, and MULTU as an iterative shift-add into HI/LO.
- Valid/ready handshake toward the pipeline; busy stalls the pipeline during multiply.

Parameters:
- WIDTH, 32: operand/result width; HI and LO are each WIDTH bits.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept; low while multiply in progress
- alu_ctrl  in  6  ALU control code
- op_a  in  WIDTH  operand A (rs)
- op_b  in  WIDTH  operand B (rt/immediate)
- flush  in  1  synchronous abort of in-flight operation
- result_valid  out  1  one-cycle pulse, result/zero valid
- result  out  WIDTH  operation result
- zero  out  1  result == 0, qualified by result_valid
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  multiply iterating (= !in_ready)
- ovf  out  1  signed overflow; present only with ALU_EXEC_OVF_EN

Behaviour:
- Reset (async, rst_n=0): state IDLE, in_ready=1, result_valid=0, result=0, zero=0, hi=0, lo=0, busy=0, ovf=0, iteration counter=0.
- Accept occurs when in_valid && in_ready at a rising edge.
- Single-cycle codes, result registered at the accept edge, result_valid=1 for exactly that next cycle:
  - 0x00 AND, 0x01 OR, 0x04 XOR.
  - 0x02 ADD, 0x03 ADDU: a+b mod 2^WIDTH.
  - 0x06 SUB: a-b.
  - 0x07 SLT: signed a<b ? 1 : 0.
  - 0x08 SLTU: unsigned compare.
  - 0x09 LUI: b<<16.
  - 0x0A/0x0B/0x0C SLL b by 1/2/8.
  - 0x0D/0x0E/0x0F SRL b by 1/2/8.
  - 0x10/0x11/0x12 SRA b by 1/2/8 (sign fill).
- Any other code (including 0x05, 0x14–0x3F): result=0, zero=1, 1-cycle latency, no HI/LO change.
- 0x13 MULTU, state machine IDLE -> MUL -> IDLE:
  - On accept: latch a as multiplicand and b as multiplier, clear the 2*WIDTH accumulator, counter=0, go to MUL; in_ready=0, busy=1.
  - MUL: one multiplier bit per cycle (LSB first); add multiplicand<<counter when the bit is set; counter increments.
  - Exit after WIDTH iterations. At edge t+WIDTH+1 (accept at t), {hi,lo} <= product, result <= low half, result_valid pulses 1 cycle, state returns to IDLE, in_ready=1.
  - Back-to-back: a new op may be accepted in the same cycle result_valid is high.
- flush:
  - Returns state to IDLE and clears result_valid at the next edge.
  - Aborted multiply leaves hi/lo unchanged.
  - flush && in_valid in the same cycle: flush wins, input is not accepted.
- result_valid is never asserted without a prior accept. hi/lo change only on MULTU completion.
- Reset mid-multiply: immediate return to reset values; HI/LO are cleared.

Optional Feature:
- Macro ALU_EXEC_OVF_EN.
- Defined: ovf port exists.
  - For 0x02: ovf=1 when the operand signs are equal and the result sign differs.
  - For 0x06: ovf=1 when the operand signs differ and the result sign differs from a.
  - Driven alongside result_valid; 0 for all other codes.
  - Result is still written (trap handling lives elsewhere).
- Undefined: no ovf port, no overflow logic.

Decomposition:
- Shared package alu_pkg: localparams for every ALU control code (ALU_AND..ALU_MULTU, ALU_REF=0x14 reserved), state encoding (ST_IDLE, ST_MUL), width of the control code (6).
- One sub-module alu_mul_iter: iterative unsigned shift-add multiplier with start/done, WIDTH parameter, 2*WIDTH product. Top holds the handshake, the single-cycle datapath and HI/LO.

Test Plan:
- Reset asserted mid-multiply at cycle 10 -> all outputs 0 immediately, in_ready=1 after release.
- ADD 0x7FFFFFFF+1 (ctrl 0x02) -> result 0x80000000 one cycle later, zero=0, ovf=1 if enabled; SUB 5-5 -> result 0, zero=1.
- SRA 0x80000000 by 8 (ctrl 0x12) -> 0xFF800000; SRL same -> 0x00800000; SLL 0x1 by 2 -> 0x4; LUI b=0x1234 -> 0x12340000.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> in_ready low 33 cycles, hi=0xFFFFFFFE, lo=0x00000001, result_valid single pulse, next ADD accepted that cycle.
- MULTU 3*4 with flush at iteration 5 -> no result_valid, hi/lo keep the prior values; ctrl 0x14 and 0x3F -> result 0, zero=1.
